// File: rtl/spi_line_fetcher.sv
// spi_line_fetcher: one SPI READ burst per scanline that fills the line buffer. Define SPI_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy bits.
module spi_line_fetcher #(
  parameter int          BYTES_PER_LINE = 16,
  parameter int          LINE_STRIDE    = 16,
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int          M0_V_VIEW      = 480,
  parameter int          M1_V_VIEW      = 900
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mode,
  input  logic       i_hmax,
  input  logic       i_vmax,
  input  logic [9:0] i_vpos,
  output logic       spi_csb,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       o_wr_en,
  output logic [5:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_overrun
);
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
`endif
  localparam logic [8:0] DATA_LAST = 9'(8 * BYTES_PER_LINE - 1);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q;
  logic [31:0] sr_q;
  logic [6:0]  rx_q;
  logic        csb_q, sclk_q, mosi_q, wr_en_q, busy_q, ovr_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [10:0] next_line;
  logic        visible, last;
  logic [23:0] addr_d;

  // next display line, whether it is visible, and its ROM address (wraps at 24 bits)
  always_comb begin
    next_line = i_vmax ? 11'd0 : {1'b0, i_vpos} + 11'd1;
    visible   = next_line < (i_mode ? 11'(M1_V_VIEW) : 11'(M0_V_VIEW));
    addr_d    = BASE_ADDR + 24'(next_line) * 24'(LINE_STRIDE);
  end

  // last bit of the current shift phase and the phase that follows it
  always_comb begin
    last = (state_q == DATA) ? cnt_q == DATA_LAST : (state_q == ADDR) ? cnt_q == 9'd23 : cnt_q == 9'd7;
`ifdef SPI_FAST_READ_EN
    state_d = (state_q == CMD) ? ADDR : (state_q == ADDR) ? DUMMY : (state_q == DUMMY) ? DATA : GAP;
`else
    state_d = (state_q == CMD) ? ADDR : (state_q == ADDR) ? DATA : GAP;
`endif
  end

  // burst sequencer: two clocks per bit, MOSI moves as SCLK falls, MISO sampled as SCLK falls
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      rx_q      <= '0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (i_hmax && busy_q) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (i_hmax && visible) begin
          state_q <= CMD;
          cnt_q   <= '0;
          csb_q   <= 1'b0;
          busy_q  <= 1'b1;
          sclk_q  <= 1'b0;
          sr_q    <= {RD_CMD, addr_d};
          mosi_q  <= RD_CMD[7];
        end
        GAP: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q[0]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          sclk_q <= ~sclk_q;
          if (sclk_q) begin
            sr_q   <= sr_q << 1;
            mosi_q <= sr_q[30];
            rx_q   <= {rx_q[5:0], spi_miso};
            cnt_q  <= last ? 9'd0 : cnt_q + 9'd1;
            if (last) state_q <= state_d;
            if (state_q == DATA && cnt_q[2:0] == 3'd7) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[8:3];
              wr_data_q <= {rx_q, spi_miso};
            end
            if (state_q == DATA && last) csb_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign spi_csb   = csb_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = busy_q;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_spi_line_fetcher.sv
// tb_spi_line_fetcher: randomized bench for spi_line_fetcher with a behavioural SPI ROM and line model
module tb_spi_line_fetcher;
  localparam int          B      = 16;
  localparam int          STRIDE = 16;
  localparam logic [23:0] BASE   = 24'h000000;
`ifdef SPI_FAST_READ_EN
  localparam int          HDR     = 40;
  localparam logic [7:0]  EXP_CMD = 8'h0B;
`else
  localparam int          HDR     = 32;
  localparam logic [7:0]  EXP_CMD = 8'h03;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic       i_mode = 1'b0, i_hmax = 1'b0, i_vmax = 1'b0;
  logic [9:0] i_vpos = '0;
  logic       spi_csb, spi_sclk, spi_mosi, spi_miso = 1'b0;
  logic       o_wr_en, o_busy, o_overrun;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;

  spi_line_fetcher #(.BYTES_PER_LINE(B), .LINE_STRIDE(STRIDE), .BASE_ADDR(BASE),
                     .M0_V_VIEW(480), .M1_V_VIEW(900)) dut (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_hmax(i_hmax), .i_vmax(i_vmax), .i_vpos(i_vpos),
    .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_overrun(o_overrun));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ROM content is a fixed function of address so a wrong address shows up as wrong data
  logic [7:0] rom_xor = 8'h00;
  function automatic logic [7:0] rom(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ rom_xor;
  endfunction

  // SPI ROM: decodes command/address from MOSI on SCLK rise, presents data bits MSB first
  int          rise_n = 0, mosi_ones = 0;
  logic [7:0]  rx_cmd = '0;
  logic [23:0] rx_addr = '0;
  always @(negedge spi_csb or posedge spi_sclk) begin
    int j;
    logic [7:0] d;
    if (!spi_sclk) rise_n = 0;
    else begin
      if (rise_n < 8) rx_cmd = {rx_cmd[6:0], spi_mosi};
      else if (rise_n < 32) rx_addr = {rx_addr[22:0], spi_mosi};
      else if (spi_mosi) mosi_ones++;
      if (rise_n >= HDR) begin
        j = rise_n - HDR;
        d = rom(rx_addr + 24'(j / 8));
        spi_miso = d[7 - j % 8];
      end
      rise_n++;
    end
  end

  // cycle monitor sampled mid-cycle
  int   cyc = 0, csb_low_cnt = 0, busy_cnt = 0, sclk_hi_cnt = 0, last_wr_cyc = 0, csb_rise_cyc = -1, wr_dbl = 0;
  logic prev_csb = 1'b1, prev_wr = 1'b0, sclk_at_rise = 1'b0;
  int   wq_a[$], wq_d[$];
  always @(negedge clk) begin
    cyc++;
    if (!spi_csb) csb_low_cnt++;
    if (o_busy) busy_cnt++;
    if (spi_sclk) sclk_hi_cnt++;
    if (o_wr_en) begin
      wq_a.push_back(int'(o_wr_addr));
      wq_d.push_back(int'(o_wr_data));
      last_wr_cyc = cyc;
    end
    if (o_wr_en && prev_wr) wr_dbl++;
    if (spi_csb && !prev_csb) begin
      csb_rise_cyc = cyc;
      sclk_at_rise = spi_sclk;
    end
    prev_csb = spi_csb;
    prev_wr  = o_wr_en;
  end

  task automatic pulse(input logic m, input logic [9:0] vp, input logic vm);
    @(negedge clk); #1;
    i_mode = m; i_vpos = vp; i_vmax = vm; i_hmax = 1'b1;
    @(negedge clk); #1;
    i_hmax = 1'b0;
  endtask

  task automatic burst(input logic m, input logic [9:0] vp, input logic vm, input bit ovr_mid);
    int c0, b0, w0, o0, g, line;
    bit fetch;
    logic [23:0] a;
    @(negedge clk); #1;
    c0 = csb_low_cnt; b0 = busy_cnt; w0 = wq_a.size(); o0 = mosi_ones;
    line  = vm ? 0 : int'(vp) + 1;
    fetch = line < (m ? 900 : 480);
    a     = 24'(int'(BASE) + line * STRIDE);
    pulse(m, vp, vm);
    if (ovr_mid && fetch) begin
      repeat (98) @(negedge clk);
      pulse(m, vp, vm);
      exp_ovr = 1'b1;
    end
    g = 0;
    while (o_busy && g < 2000) begin
      @(negedge clk); #1;
      g++;
    end
    check("timeout", 32'(g < 2000), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    if (fetch) begin
      check("csb_low", 32'(csb_low_cnt - c0), 32'(2 * (HDR + 8 * B)));
      check("busy_len", 32'(busy_cnt - b0), 32'(2 * (HDR + 8 * B) + 2));
      check("cmd", 32'(rx_cmd), 32'(EXP_CMD));
      check("addr", 32'(rx_addr), 32'(a));
      check("nwr", 32'(wq_a.size() - w0), 32'(B));
      for (int n = 0; n < B && w0 + n < wq_a.size(); n++) begin
        check("wr_addr", 32'(wq_a[w0 + n]), 32'(n));
        check("wr_data", 32'(wq_d[w0 + n]), 32'(rom(a + 24'(n))));
      end
      check("last_wr_at_csb_rise", 32'(last_wr_cyc), 32'(csb_rise_cyc));
      check("sclk_at_csb_rise", 32'(sclk_at_rise), 32'd0);
      check("mosi_data_zero", 32'(mosi_ones - o0), 32'd0);
    end else begin
      check("nofetch_busy", 32'(busy_cnt - b0), 32'd0);
      check("nofetch_wr", 32'(wq_a.size() - w0), 32'd0);
    end
    check("overrun", 32'(o_overrun), 32'(exp_ovr));
  endtask

  initial begin
    int c0, b0, w0, s0;
    logic m, vm;
    logic [9:0] vp;
    repeat (3) @(negedge clk);
    #1;
    check("rst_csb", 32'(spi_csb), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    reset = 1'b0;
    c0 = csb_low_cnt; b0 = busy_cnt; w0 = wq_a.size(); s0 = sclk_hi_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("idle_csb", 32'(csb_low_cnt - c0), 32'd0);
    check("idle_sclk", 32'(sclk_hi_cnt - s0), 32'd0);
    check("idle_busy", 32'(busy_cnt - b0), 32'd0);
    check("idle_wr", 32'(wq_a.size() - w0), 32'd0);

    rom_xor = 8'h00;
    burst(1'b0, 10'd9, 1'b0, 1'b0);
    burst(1'b0, 10'd479, 1'b0, 1'b0);
    burst(1'b0, 10'd479, 1'b1, 1'b0);
    burst(1'b1, 10'd899, 1'b0, 1'b0);
    burst(1'b1, 10'd899, 1'b1, 1'b0);
    burst(1'b1, 10'd500, 1'b0, 1'b0);
    burst(1'b0, 10'd30, 1'b0, 1'b1);
    burst(1'b0, 10'd31, 1'b0, 1'b0);

    pulse(1'b0, 10'd40, 1'b0);
    repeat (149) @(negedge clk);
    #1;
    reset = 1'b1;
    w0 = wq_a.size();
    @(negedge clk); #1;
    check("rstmid_csb", 32'(spi_csb), 32'd1);
    check("rstmid_sclk", 32'(spi_sclk), 32'd0);
    check("rstmid_mosi", 32'(spi_mosi), 32'd0);
    check("rstmid_wr_en", 32'(o_wr_en), 32'd0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_overrun", 32'(o_overrun), 32'd0);
    reset = 1'b0;
    exp_ovr = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("rstmid_nowr", 32'(wq_a.size() - w0), 32'd0);
    burst(1'b0, 10'd40, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom_range(0, 1));
      vm = 1'($urandom_range(0, 3) == 0);
      vp = $urandom_range(0, 1) != 0 ? (m ? 10'($urandom_range(880, 1023)) : 10'($urandom_range(460, 600)))
                                     : 10'($urandom_range(0, 1023));
      rom_xor = 8'($urandom);
      burst(m, vp, vm, 1'b0);
    end
    check("wr_single_cycle", 32'(wr_dbl), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
